// File: rtl/video_pkg.sv
// Shared types and helpers for the video sync normaliser.
package video_pkg;

    // Deepest output delay line the normaliser supports.
    localparam int PIPE_MAX = 4;

    // Sync/blank bundle carried through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } vid_ctl_t;

    // Increment that sticks at the all-ones value of a cw-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int cw);
        logic [31:0] max_val;
        max_val = (32'd1 << cw) - 32'd1;
        if (value >= max_val) begin
            return max_val;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_polarity.sv
// Polarity detector for one raw sync line. The flag is learned at each
// rising edge of the raw signal: if the high phase was longer than the low
// phase the sync is taken as active-low and the output is inverted.
module sync_polarity
    import video_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic ce_pix,
    input  logic raw,
    output logic norm,
    output logic pol
);

    logic [CW-1:0] hi_cnt;
    logic [CW-1:0] lo_cnt;
    logic          raw_prev;

    // Phase-length counters and polarity decision at each raw rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            raw_prev <= 1'b0;
            pol      <= 1'b0;
        end else if (ce_pix) begin
            raw_prev <= raw;
            if (raw && !raw_prev) begin
                pol    <= (hi_cnt > lo_cnt);
                hi_cnt <= '0;
                lo_cnt <= '0;
            end else if (raw) begin
                hi_cnt <= CW'(sat_inc(32'(hi_cnt), CW));
            end else begin
                lo_cnt <= CW'(sat_inc(32'(lo_cnt), CW));
            end
        end
    end

    assign norm = raw ^ pol;

endmodule

// File: rtl/video_sync_normalizer.sv
// Video sync normaliser: makes hs/vs active-high, aligns vs to hs rising
// edges and vb to hb falling edges, derives de, measures the active area and
// delays everything by PIPE pixel-enable cycles.
// Build option: VIDEO_NORMALIZER_BLANK_RGB_EN forces RGB to zero during
// blanking when cleaning is enabled.
module video_sync_normalizer
    import video_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CW   = 12,
    parameter int PIPE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          enable,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hb_in,
    input  logic          vb_in,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          hb_out,
    output logic          vb_out,
    output logic          de_out,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic          timing_valid
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int DEPTH = (PIPE < 1) ? 1 : ((PIPE > PIPE_MAX) ? PIPE_MAX : PIPE);
`ifdef VIDEO_NORMALIZER_BLANK_RGB_EN
    localparam int WW = 3*DW + 6;
`else
    localparam int WW = 3*DW + 5;
`endif

    logic     norm_hs;
    logic     norm_vs;
    logic     hs_pol_unused;
    logic     vs_pol_unused;

    sync_polarity #(.CW(CW)) u_hs_pol (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce_pix),
        .raw    (hs_in),
        .norm   (norm_hs),
        .pol    (hs_pol_unused)
    );

    sync_polarity #(.CW(CW)) u_vs_pol (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce_pix),
        .raw    (vs_in),
        .norm   (norm_vs),
        .pol    (vs_pol_unused)
    );

    // ---- stage p0: alignment (combinational on current inputs) ----
    logic     prev_hs;
    logic     prev_hb;
    logic     vs_hold;
    logic     vb_hold;
    logic     hbl_p0;
    logic     vbl_p0;
    logic     hs_rise_p0;
    logic     hb_fall_p0;
    vid_ctl_t aln_ctl_p0;
    vid_ctl_t raw_ctl_p0;
    logic     de_aln_p0;

    assign hbl_p0     = norm_hs | hb_in;
    assign vbl_p0     = norm_vs | vb_in;
    assign hs_rise_p0 = norm_hs & ~prev_hs;
    assign hb_fall_p0 = prev_hb & ~hbl_p0;

    assign aln_ctl_p0.hs = norm_hs;
    assign aln_ctl_p0.vs = hs_rise_p0 ? norm_vs : vs_hold;
    assign aln_ctl_p0.hb = hbl_p0;
    assign aln_ctl_p0.vb = hb_fall_p0 ? vbl_p0 : vb_hold;
    assign de_aln_p0     = ~(aln_ctl_p0.hb | aln_ctl_p0.vb);

    assign raw_ctl_p0 = '{hs: hs_in, vs: vs_in, hb: hb_in, vb: vb_in};

    // Edge history for alignment; the hold registers are the last aligned vs/vb.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_hs <= 1'b0;
            prev_hb <= 1'b0;
            vs_hold <= 1'b0;
            vb_hold <= 1'b0;
        end else if (ce_pix) begin
            prev_hs <= norm_hs;
            prev_hb <= hbl_p0;
            vs_hold <= aln_ctl_p0.vs;
            vb_hold <= aln_ctl_p0.vb;
        end
    end

    // ---- measurement on the aligned blanks (independent of enable) ----
    logic          hb_rise_p0;
    logic          vb_rise_p0;
    logic [CW-1:0] px_cnt;
    logic [CW-1:0] ln_cnt;
    logic [CW-1:0] prev_h;
    logic [CW-1:0] prev_v;
    logic          frame_seen;
    logic          pair_seen;

    assign hb_rise_p0 = aln_ctl_p0.hb & ~prev_hb;
    assign vb_rise_p0 = aln_ctl_p0.vb & ~vb_hold;

    // Pixel/line counting; frame end latches height and compares against the last frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            px_cnt       <= '0;
            ln_cnt       <= '0;
            prev_h       <= '0;
            prev_v       <= '0;
            h_active     <= '0;
            v_active     <= '0;
            timing_valid <= 1'b0;
            frame_seen   <= 1'b0;
            pair_seen    <= 1'b0;
        end else if (ce_pix) begin
            if (hb_rise_p0) begin
                if (px_cnt != '0) begin
                    h_active <= px_cnt;
                    ln_cnt   <= CW'(sat_inc(32'(ln_cnt), CW));
                end
                px_cnt <= '0;
            end else if (de_aln_p0) begin
                px_cnt <= CW'(sat_inc(32'(px_cnt), CW));
            end
            // vb only rises on an hb falling edge, so it never meets hb_rise.
            if (vb_rise_p0) begin
                if (frame_seen) begin
                    v_active     <= ln_cnt;
                    timing_valid <= pair_seen && (h_active == prev_h) && (ln_cnt == prev_v);
                    prev_h       <= h_active;
                    prev_v       <= ln_cnt;
                    pair_seen    <= 1'b1;
                end else begin
                    // Partial first frame after reset is thrown away.
                    frame_seen <= 1'b1;
                    px_cnt     <= '0;
                end
                ln_cnt <= '0;
            end
        end
    end

    // ---- delay line p1..pN: {rgb, ctl, de[, blank-allowed]} ----
    logic [WW-4-1-DW*3+3*DW+4:0] word_core_p0;
    logic [WW-1:0]               word_p0;
    logic [WW-1:0]               dl [DEPTH];

    always_comb begin
        if (enable) begin
            word_core_p0 = {r_in, g_in, b_in, aln_ctl_p0, de_aln_p0};
        end else begin
            word_core_p0 = {r_in, g_in, b_in, raw_ctl_p0, ~(hb_in | vb_in)};
        end
    end

`ifdef VIDEO_NORMALIZER_BLANK_RGB_EN
    assign word_p0 = {word_core_p0, enable};
`else
    assign word_p0 = word_core_p0;
`endif

    // Shift register advancing one slot per pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl[i] <= '0;
            end
        end else if (ce_pix) begin
            dl[0] <= word_p0;
            for (int i = 1; i < DEPTH; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // ---- output stage ----
    logic [DW-1:0] r_q;
    logic [DW-1:0] g_q;
    logic [DW-1:0] b_q;
    vid_ctl_t      out_ctl;
    logic          de_q;
    logic          blank;

`ifdef VIDEO_NORMALIZER_BLANK_RGB_EN
    logic blank_ok;
    assign {r_q, g_q, b_q, out_ctl, de_q, blank_ok} = dl[DEPTH-1];
    assign blank = blank_ok & (out_ctl.hb | out_ctl.vb);
`else
    assign {r_q, g_q, b_q, out_ctl, de_q} = dl[DEPTH-1];
    assign blank = 1'b0;
`endif

    assign r_out  = blank ? '0 : r_q;
    assign g_out  = blank ? '0 : g_q;
    assign b_out  = blank ? '0 : b_q;
    assign hs_out = out_ctl.hs;
    assign vs_out = out_ctl.vs;
    assign hb_out = out_ctl.hb;
    assign vb_out = out_ctl.vb;
    assign de_out = de_q;

endmodule

// File: tb/tb_video_sync_normalizer.sv
// Directed bench for video_sync_normalizer with a scaled-down raster:
// 32 pixels/line (hs active-low for 4, 20 active pixels), 10 lines/frame
// (vs active-low for 2 lines, toggled mid-line), PIPE = 3.
module tb_video_sync_normalizer;

    localparam int P = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] r_in = 8'h00;
    logic [7:0] g_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       hs_in = 1'b1;
    logic       vs_in = 1'b1;
    logic       hb_in = 1'b0;
    logic       vb_in = 1'b0;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic       hs_out;
    logic       vs_out;
    logic       hb_out;
    logic       vb_out;
    logic       de_out;
    logic [11:0] h_active;
    logic [11:0] v_active;
    logic        timing_valid;

    int total = 0;
    int bad   = 0;

    logic [28:0] eh [P];
    bit          ec [P];

    video_sync_normalizer #(.DW(8), .CW(12), .PIPE(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce_pix       (ce_pix),
        .enable       (enable),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .hb_in        (hb_in),
        .vb_in        (vb_in),
        .r_out        (r_out),
        .g_out        (g_out),
        .b_out        (b_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .hb_out       (hb_out),
        .vb_out       (vb_out),
        .de_out       (de_out),
        .h_active     (h_active),
        .v_active     (v_active),
        .timing_valid (timing_valid)
    );

    always #5 clk = ~clk;

    logic [28:0] out_vec;
    assign out_vec = {hs_out, vs_out, hb_out, vb_out, de_out, r_out, g_out, b_out};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Raw raster {hs, vs, hb, vb} at line y, pixel x.
    function automatic logic [3:0] raw_ctl(input int y, input int x, input int vact);
        logic hs, vs, hb, vb;
        hs = (x >= 4);
        vs = !((y == 0 && x >= 10) || y == 1 || (y == 2 && x < 10));
        hb = (x < 8) || (x >= 28);
        vb = (y < 3) || (y == 3 && x < 10) || (y > 3 + vact) || (y == 3 + vact && x >= 10);
        return {hs, vs, hb, vb};
    endfunction

    // Hand-derived steady-state output word (6 active lines) for input at (y, x).
    function automatic logic [28:0] exp_word(input int y, input int x, input logic en);
        logic hs, vs, hb, vb, de;
        if (en) begin
            hs = (x < 4);
            vs = (y == 1 || y == 2);
            hb = (x < 8) || (x >= 28);
            vb = (x >= 8) ? (y <= 3) : (y >= 1 && y <= 4);
        end else begin
            {hs, vs, hb, vb} = raw_ctl(y, x, 6);
        end
        de = !(hb | vb);
`ifdef VIDEO_NORMALIZER_BLANK_RGB_EN
        if (en && (hb | vb)) begin
            return {hs, vs, hb, vb, de, 24'h000000};
        end
`endif
        return {hs, vs, hb, vb, de, 8'hFF, 8'(x), 8'(y)};
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < P; i++) begin
            eh[i] = '0;
            ec[i] = 1'b0;
        end
    endtask

    task automatic step(input int y, input int x, input int vact, input logic en,
                        input int ce_div, input bit chk);
        {hs_in, vs_in, hb_in, vb_in} = raw_ctl(y, x, vact);
        r_in   = 8'hFF;
        g_in   = 8'(x);
        b_in   = 8'(y);
        enable = en;
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
        for (int i = P - 1; i > 0; i--) begin
            eh[i] = eh[i-1];
            ec[i] = ec[i-1];
        end
        eh[0] = exp_word(y, x, en);
        ec[0] = chk;
        if (ec[P-1]) check_val("px", 32'(out_vec), 32'(eh[P-1]));
        ce_pix = 1'b0;
        for (int k = 1; k < ce_div; k++) begin
            @(posedge clk);
            #1;
            if (ec[P-1]) check_val("hold", 32'(out_vec), 32'(eh[P-1]));
        end
    endtask

    task automatic pulse_reset();
        reset  = 1'b1;
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_out", 32'(out_vec), 32'h0);
        check_val("rst_meas", {7'd0, h_active, v_active, timing_valid}, 32'h0);
        reset = 1'b0;
        clear_hist();
    endtask

    task automatic run_frame(input int vact, input logic en, input int ce_div, input bit chk,
                             input int rst_y, input int rst_x);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 32; x++) begin
                if (y == rst_y && x == rst_x) pulse_reset();
                step(y, x, vact, en, ce_div, chk);
            end
        end
    endtask

    task automatic check_meas(input string tag, input int h, input int v, input logic tv);
        check_val({tag, "_h"}, 32'(h_active), 32'(h));
        check_val({tag, "_v"}, 32'(v_active), 32'(v));
        check_val({tag, "_tv"}, 32'(timing_valid), 32'(tv));
    endtask

    initial begin
        clear_hist();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out", 32'(out_vec), 32'h0);
        check_val("reset_meas", {7'd0, h_active, v_active, timing_valid}, 32'h0);
        reset = 1'b0;

        // Cleaning mode: polarity learning settles during frames 0-1.
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        run_frame(6, 1'b1, 1, 1'b1, -1, -1);
        check_meas("f2", 20, 6, 1'b0);
        run_frame(6, 1'b1, 1, 1'b1, -1, -1);
        check_meas("f3", 20, 6, 1'b1);

        // One short frame breaks timing_valid; it returns after two good frames.
        run_frame(5, 1'b1, 1, 1'b0, -1, -1);
        check_meas("f4", 20, 5, 1'b0);
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        check_meas("f5", 20, 5, 1'b0);
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        check_meas("f6", 20, 6, 1'b0);
        run_frame(6, 1'b1, 1, 1'b1, -1, -1);
        check_meas("f7", 20, 6, 1'b1);

        // Passthrough with a 1-in-4 pixel enable; measurement keeps running.
        run_frame(6, 1'b0, 4, 1'b0, -1, -1);
        run_frame(6, 1'b0, 4, 1'b1, -1, -1);
        check_meas("f9", 20, 6, 1'b1);

        // Reset mid-line; timing_valid must wait for the third vb rise.
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        run_frame(6, 1'b1, 1, 1'b0, 5, 15);
        check_val("f11_tv", 32'(timing_valid), 32'h0);
        check_val("f11_v", 32'(v_active), 32'h0);
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        check_val("f12_tv", 32'(timing_valid), 32'h0);
        run_frame(6, 1'b1, 1, 1'b0, -1, -1);
        check_meas("f13", 20, 6, 1'b0);
        run_frame(6, 1'b1, 1, 1'b1, -1, -1);
        check_meas("f14", 20, 6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
